spi_readback_resp: RTL and testbench
====================================

Name: spi_readback_resp

Overview:
- SPI-slave responder that drives the MISO pin, currently tied low, so the MMC can read back registers over the existing config SPI wires (SCLK/CSB/MOSI).
- Oversamples the SPI pins in the `clk` (tx_clk/lb_clk) domain and decodes an address phase.
- Issues a single-cycle read request to a local register source, then shifts the returned word out MSB-first.
- Runs alongside spi_gate on the same pins; it never drives MOSI/SCLK/CSB.

Parameters:
- aw, 8, address bits received per frame.
- dw, 32, data bits shifted out per frame.
- turn, 8, turnaround (dummy) bits between address and data.
- nsync, 2, synchronizer flop stages on SCLK/CSB/MOSI (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCLK frequency.
- rst  input  1  asynchronous, active-high reset.
- SCLK  input  1  SPI clock from MMC, mode 0 (idle low, sample on rising edge).
- CSB  input  1  SPI chip select, active low.
- MOSI  input  1  SPI data from MMC.
- MISO  output  1  SPI data to MMC.
- rd_addr  output  aw  captured read address; held until the next frame's address completes.
- rd_strobe  output  1  one-clk pulse requesting a read at rd_addr.
- rd_data  input  dw  read data, sampled when rd_valid is high.
- rd_valid  input  1  read data qualifier.
- timeout  output  1  one-clk pulse when data is not available in time.
- frame_cnt  output  16  count of completed data phases; wraps 0xFFFF->0.

Behaviour:
- Reset values: MISO=0, rd_addr=0, rd_strobe=0, timeout=0, frame_cnt=0, state=IDLE, all synchronizer flops set to the idle pin levels (SCLK=0, CSB=1).
- Input path: nsync-stage synchronizers, plus one history flop per signal.
- Edge detection:
  - rise = SCLK went 0->1 in the synchronized domain.
  - fall = SCLK went 1->0 in the synchronized domain.
  - cs_act = synchronized CSB==0.
- State machine:
  - IDLE: MISO=0 and bit counter=0. Go to ADDR when cs_act.
  - ADDR: on each rise, shift the synchronized MOSI into an addr shift register, MSB first. On the aw-th rise:
    - latch rd_addr;
    - pulse rd_strobe for exactly 1 clk on the following cycle;
    - go to TURN.
  - TURN:
    - Counts `turn` rises.
    - MISO=0.
    - The first rd_valid seen after rd_strobe latches rd_data into the output shift register and sets have_data.
    - On the fall following the turn-th rise:
      - if have_data, MISO <= shreg[dw-1] and go to DATA;
      - otherwise load shreg=all-ones, MISO=1, pulse timeout for 1 clk, and go to DATA.
  - DATA:
    - On each fall, shift shreg left and drive MISO <= new MSB.
    - After the dw-th rise of the data phase, increment frame_cnt and go to DONE.
  - DONE: MISO=0; further SCLK edges are ignored until CSB deasserts.
- CSB deassert (cs_act=0) in any state: next clk go to IDLE, MISO=0, have_data cleared; any in-progress frame is aborted.
  - Abort in ADDR: no rd_strobe is issued and rd_addr is unchanged.
  - Abort in TURN/DATA: frame_cnt is not incremented.
- rd_valid outside TURN, a second rd_valid in the same TURN, or rd_valid arriving after the timeout decision: ignored.
- rd_valid in the same clk as the decision fall: counts as on time.
- rise and CSB deassert detected in the same clk: CSB deassert wins.
- Latency from pin edge to MISO change: nsync+2 clk maximum.
- MMC-side timing: the MISO bit driven after fall k is sampled at rise k+1.
- Source read latency available: turn-1 SCLK periods minus (nsync+3) clk.

Test Plan:
- Normal read: frame with addr 0x5A, rd_valid 3 clk after rd_strobe with rd_data=0x12345678 -> rd_strobe pulses once with rd_addr=0x5A; MMC samples 0x12345678; frame_cnt 0->1; timeout never asserts.
- Timeout: rd_valid never asserted -> timeout pulses once at the end of TURN; MMC reads 0xFFFFFFFF; frame_cnt increments.
- Late data: rd_valid arrives during DATA -> ignored; output is 0xFFFFFFFF.
- Abort in ADDR: CSB raised after 5 address bits -> no rd_strobe; rd_addr keeps its previous value; MISO=0; the next full frame with addr 0x01 reads correctly.
- Abort in DATA: CSB raised after 10 data bits -> frame_cnt unchanged; MISO returns to 0 within nsync+2 clk.
- Back-to-back frames with addr 0x00 then 0xFF, and reads 0xAAAA5555 then 0x0000FFFF -> both data words are correct; frame_cnt=2.
- Async reset asserted mid-DATA -> MISO=0 and all outputs at reset values immediately.
- Wrap: frame_cnt preset via 65536 frames (or a force) -> 0xFFFF wraps to 0.

Source files
------------

// File: rtl/spi_readback_resp.sv
// SPI mode-0 slave that answers MMC register reads on MISO.
// SPI pins are oversampled in the clk domain; the read word comes from a local source.
module spi_readback_resp #(
    parameter int aw    = 8,
    parameter int dw    = 32,
    parameter int turn  = 8,
    parameter int nsync = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          SCLK,
    input  logic          CSB,
    input  logic          MOSI,
    output logic          MISO,
    output logic [aw-1:0] rd_addr,
    output logic          rd_strobe,
    input  logic [dw-1:0] rd_data,
    input  logic          rd_valid,
    output logic          timeout,
    output logic [15:0]   frame_cnt
);

    localparam int cw = $clog2(aw + dw + turn + 1);
    localparam logic [cw-1:0] one      = cw'(1);
    localparam logic [cw-1:0] aw_last  = cw'(aw - 1);
    localparam logic [cw-1:0] turn_end = cw'(turn);
    localparam logic [cw-1:0] dw_last  = cw'(dw - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        TURN,
        DATA,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [nsync-1:0] sclk_q, csb_q, mosi_q;
    logic             sclk_d;
    logic             sclk_s, csb_s, mosi_s;
    logic             rise, fall, cs_act;

    logic [cw-1:0] cnt, cnt_nxt;
    logic [aw-1:0] addr_sh, addr_sh_nxt;
    logic [dw-1:0] shreg, sh_nxt;
    logic          have_data, have_nxt;
    logic          miso_nxt;
    logic          ld_addr;
    logic          to_nxt;
    logic          frame_inc;

    // Idle pin levels are preloaded so reset release cannot fake an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '0;
            csb_q  <= '1;
            mosi_q <= '0;
            sclk_d <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[nsync-2:0], SCLK};
            csb_q  <= {csb_q[nsync-2:0], CSB};
            mosi_q <= {mosi_q[nsync-2:0], MOSI};
            sclk_d <= sclk_s;
        end
    end

    assign sclk_s = sclk_q[nsync-1];
    assign csb_s  = csb_q[nsync-1];
    assign mosi_s = mosi_q[nsync-1];
    assign rise   = sclk_s & ~sclk_d;
    assign fall   = ~sclk_s & sclk_d;
    assign cs_act = ~csb_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_sh   <= '0;
            shreg     <= '0;
            have_data <= 1'b0;
            MISO      <= 1'b0;
            rd_addr   <= '0;
            rd_strobe <= 1'b0;
            timeout   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            addr_sh   <= addr_sh_nxt;
            shreg     <= sh_nxt;
            have_data <= have_nxt;
            MISO      <= miso_nxt;
            rd_strobe <= ld_addr;
            timeout   <= to_nxt;
            if (ld_addr)
                rd_addr <= addr_sh_nxt;
            if (frame_inc)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        addr_sh_nxt = addr_sh;
        sh_nxt      = shreg;
        have_nxt    = have_data;
        miso_nxt    = 1'b0;
        ld_addr     = 1'b0;
        to_nxt      = 1'b0;
        frame_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (cs_act)
                    state_nxt = ADDR;
            end
            ADDR: begin
                if (rise) begin
                    addr_sh_nxt = {addr_sh[aw-2:0], mosi_s};
                    cnt_nxt     = cnt + one;
                    if (cnt == aw_last) begin
                        ld_addr   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = TURN;
                    end
                end
            end
            TURN: begin
                if (rd_valid && !have_data) begin
                    have_nxt = 1'b1;
                    sh_nxt   = rd_data;
                end
                if (rise)
                    cnt_nxt = cnt + one;
                // Data landing on the decision cycle itself is still on time.
                if (fall && cnt == turn_end) begin
                    cnt_nxt   = '0;
                    state_nxt = DATA;
                    if (have_nxt) begin
                        miso_nxt = sh_nxt[dw-1];
                    end else begin
                        sh_nxt   = '1;
                        miso_nxt = 1'b1;
                        to_nxt   = 1'b1;
                    end
                end
            end
            DATA: begin
                miso_nxt = MISO;
                if (fall) begin
                    sh_nxt   = {shreg[dw-2:0], 1'b0};
                    miso_nxt = shreg[dw-2];
                end
                if (rise) begin
                    cnt_nxt = cnt + one;
                    if (cnt == dw_last) begin
                        frame_inc = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                miso_nxt = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Chip-select release aborts any frame and outranks a same-cycle edge.
        if (!cs_act) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            have_nxt  = 1'b0;
            miso_nxt  = 1'b0;
            ld_addr   = 1'b0;
            to_nxt    = 1'b0;
            frame_inc = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_readback_resp.sv
// Bench for spi_readback_resp: an MMC-side SPI master plus a local read source,
// with a scoreboard comparing strobed addresses and words read back over MISO.
`timescale 1ns/1ps
module tb_spi_readback_resp;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int TURN  = 8;
    localparam int NSYNC = 2;
    localparam int HALF  = 80;

    logic          clk = 1'b0;
    logic          rst;
    logic          SCLK;
    logic          CSB;
    logic          MOSI;
    logic          MISO;
    logic [AW-1:0] rd_addr;
    logic          rd_strobe;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          timeout;
    logic [15:0]   frame_cnt;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          to_cnt = 0;
    int          rd_lat = -1;
    logic [31:0] rd_word = '0;

    logic [7:0]  exp_addr[$];
    logic [31:0] exp_word[$];
    logic [31:0] got_q[$];

    spi_readback_resp #(
        .aw(AW), .dw(DW), .turn(TURN), .nsync(NSYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .SCLK(SCLK),
        .CSB(CSB),
        .MOSI(MOSI),
        .MISO(MISO),
        .rd_addr(rd_addr),
        .rd_strobe(rd_strobe),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .timeout(timeout),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_miso"}, 32'(MISO), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_rd_strobe"}, 32'(rd_strobe), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes or a word completes.
    always @(negedge clk) begin
        if (timeout === 1'b1)
            to_cnt++;
        if (rd_strobe === 1'b1) begin
            if (exp_addr.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_strobe: unexpected pulse at rd_addr 0x%02h, required none",
                         rd_addr);
            end else begin
                chk("rd_addr", 32'(rd_addr), 32'(exp_addr.pop_front()));
            end
        end
        while (got_q.size() > 0) begin
            if (exp_word.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL miso_word: got 0x%08h, required no word",
                         got_q.pop_front());
            end else begin
                chk("miso_word", got_q.pop_front(), exp_word.pop_front());
            end
        end
    end

    // Local register source answering each strobe after rd_lat clocks.
    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rd_strobe === 1'b1 && rd_lat >= 0) begin
                repeat (rd_lat) @(posedge clk);
                #1;
                rd_data  = rd_word;
                rd_valid = 1'b1;
                @(posedge clk);
                #1;
                rd_valid = 1'b0;
                rd_data  = '0;
            end
        end
    end

    // mode 0 normal, 1 CSB abort after nb address bits,
    // 2 CSB abort after nb data bits, 3 async reset after nb data bits.
    task automatic frame(input logic [7:0] addr, input logic [31:0] word,
                         input int lat, input int mode, input int nb,
                         input logic [31:0] exp);
        logic [31:0] got;
        got     = '0;
        rd_word = word;
        rd_lat  = lat;
        if (mode != 1)
            exp_addr.push_back(addr);
        if (mode == 0)
            exp_word.push_back(exp);
        @(negedge clk);
        CSB = 1'b0;
        for (int i = AW - 1; i >= 0; i--) begin
            MOSI = addr[i];
            #(HALF);
            SCLK = 1'b1;
            #(HALF);
            SCLK = 1'b0;
            if (mode == 1 && (AW - i) == nb) begin
                CSB  = 1'b1;
                MOSI = 1'b0;
                repeat (NSYNC + 2) @(posedge clk);
                #1;
                chk("addr_abort_miso", 32'(MISO), 32'd0);
                chk("addr_abort_rd_addr", 32'(rd_addr), exp);
                @(negedge clk);
                #(4 * HALF);
                return;
            end
        end
        MOSI = 1'b0;
        for (int i = 0; i < TURN; i++) begin
            #(HALF);
            SCLK = 1'b1;
            #(HALF);
            SCLK = 1'b0;
        end
        for (int i = 0; i < DW; i++) begin
            #(HALF);
            got  = {got[30:0], MISO};
            SCLK = 1'b1;
            #(HALF);
            SCLK = 1'b0;
            if ((mode == 2 || mode == 3) && (i + 1) == nb) begin
                #(HALF);
                chk("miso_before_abort", 32'(MISO), 32'(word[DW-1-nb]));
                if (mode == 2) begin
                    CSB = 1'b1;
                    repeat (NSYNC + 2) @(posedge clk);
                    #1;
                    chk("data_abort_miso", 32'(MISO), 32'd0);
                end else begin
                    #3;
                    rst = 1'b1;
                    #1;
                    chk_reset_outputs("async_rst");
                    CSB = 1'b1;
                    repeat (3) @(negedge clk);
                    rst = 1'b0;
                end
                @(negedge clk);
                #(4 * HALF);
                return;
            end
        end
        #(HALF);
        CSB = 1'b1;
        got_q.push_back(got);
        #(4 * HALF);
    endtask

    initial begin
        rst  = 1'b1;
        SCLK = 1'b0;
        CSB  = 1'b1;
        MOSI = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        frame(8'h5A, 32'h12345678, 3, 0, 0, 32'h12345678);
        chk("normal_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("normal_timeouts", 32'(to_cnt), 32'd0);

        frame(8'h33, 32'h87654321, -1, 0, 0, 32'hFFFFFFFF);
        chk("timeout_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("timeout_pulses", 32'(to_cnt), 32'd1);

        frame(8'h44, 32'h0BADF00D, 150, 0, 0, 32'hFFFFFFFF);
        chk("late_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("late_pulses", 32'(to_cnt), 32'd2);

        frame(8'hC3, 32'h0, 3, 1, 5, 32'h00000044);
        chk("addr_abort_frame_cnt", 32'(frame_cnt), 32'd3);
        frame(8'h01, 32'hCAFEBABE, 3, 0, 0, 32'hCAFEBABE);
        chk("after_abort_frame_cnt", 32'(frame_cnt), 32'd4);

        frame(8'h22, 32'h12345678, 3, 2, 10, 32'h0);
        chk("data_abort_frame_cnt", 32'(frame_cnt), 32'd4);

        frame(8'h00, 32'hAAAA5555, 3, 0, 0, 32'hAAAA5555);
        frame(8'hFF, 32'h0000FFFF, 3, 0, 0, 32'h0000FFFF);
        chk("b2b_frame_cnt", 32'(frame_cnt), 32'd6);
        chk("b2b_rd_addr_hold", 32'(rd_addr), 32'h000000FF);

        frame(8'h77, 32'h55AA55AA, 3, 3, 5, 32'h0);
        chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);

        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        chk("preset_frame_cnt", 32'(frame_cnt), 32'h0000FFFF);
        frame(8'h10, 32'h01020304, 3, 0, 0, 32'h01020304);
        chk("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

        repeat (4) @(negedge clk);
        chk("addr_queue_left", 32'(exp_addr.size()), 32'd0);
        chk("word_queue_left", 32'(exp_word.size()), 32'd0);
        chk("total_timeouts", 32'(to_cnt), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
